// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and state encodings for the 9N1 serial link.
// Imported by the bit timer, transmitter, receiver and top.
package uart_pkg;

    localparam int DATA_BITS        = 9;
    localparam int FRAME_BITS       = 11;
    localparam int CLKS_PER_BIT_DEF = 16;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/uart_9n1_if.sv
// uart_9n1_if: parallel-side bundle of the serial link.
// master is the host side, slave is the UART block.
interface uart_9n1_if;
    import uart_pkg::*;

    logic                 send;
    logic [DATA_BITS-1:0] tx_data;
    logic                 ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 done;
    logic                 framing_error;

    modport master (
        output send, tx_data,
        input  ready, rx_data, done, framing_error
    );

    modport slave (
        input  send, tx_data,
        output ready, rx_data, done, framing_error
    );

endinterface

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running bit-period counter with clear.
// half_tick marks mid-bit, full_tick marks the last cycle of a bit.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    output logic half_tick,
    output logic full_tick
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt;

    assign half_tick = (cnt == CW'(CLKS_PER_BIT/2 - 1));
    assign full_tick = (cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (clear || full_tick)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 9N1 deserializer with mid-bit sampling and framing check.
// A start bit that is high at mid-bit is dropped as a glitch.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 done,
    output logic                 framing_error
);
    rx_state_t            state, state_d;
    logic [1:0]           sync;
    logic                 rx_s;
    logic [DATA_BITS-1:0] shreg, shreg_d;
    logic [3:0]           idx, idx_d;
    logic                 done_d, fe_d;
    logic                 half_tick, full_tick;

    assign rx_s = sync[1];

    // Realign on the start-bit midpoint so full ticks land mid-bit
    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     ((state == RX_IDLE) ||
                    (state == RX_START && half_tick)),
        .half_tick (half_tick),
        .full_tick (full_tick)
    );

    always_comb begin
        state_d = state;
        shreg_d = shreg;
        idx_d   = idx;
        done_d  = 1'b0;
        fe_d    = 1'b0;
        unique case (state)
            RX_IDLE: begin
                idx_d = '0;
                if (!rx_s) state_d = RX_START;
            end
            RX_START: if (half_tick)
                state_d = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA: if (full_tick) begin
                shreg_d = {rx_s, shreg[DATA_BITS-1:1]};
                if (idx == 4'(DATA_BITS - 1))
                    state_d = RX_STOP;
                else
                    idx_d = idx + 4'd1;
            end
            RX_STOP: if (full_tick) begin
                if (rx_s) begin
                    done_d  = 1'b1;
                    state_d = RX_IDLE;
                end else begin
                    fe_d    = 1'b1;
                    state_d = RX_WAIT_HIGH;
                end
            end
            RX_WAIT_HIGH: if (rx_s) state_d = RX_IDLE;
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync          <= 2'b11;
            state         <= RX_IDLE;
            shreg         <= '0;
            idx           <= '0;
            data          <= '0;
            done          <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            sync          <= {sync[0], rx};
            state         <= state_d;
            shreg         <= shreg_d;
            idx           <= idx_d;
            done          <= done_d;
            framing_error <= fe_d;
            if (done_d) data <= shreg_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 9N1 serializer, LSB first, level-sensitive send.
// tx is registered from the next state so the line never glitches.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 send,
    input  logic [DATA_BITS-1:0] data,
    output logic                 tx,
    output logic                 ready
);
    tx_state_t            state, state_d;
    logic [DATA_BITS-1:0] shreg, shreg_d;
    logic [3:0]           idx, idx_d;
    logic                 tx_d;
    logic                 full_tick;
    logic                 half_unused;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (state == TX_IDLE),
        .half_tick (half_unused),
        .full_tick (full_tick)
    );

    assign ready = (state == TX_IDLE);

    always_comb begin
        state_d = state;
        shreg_d = shreg;
        idx_d   = idx;
        unique case (state)
            TX_IDLE: if (send) begin
                state_d = TX_START;
                shreg_d = data;
                idx_d   = '0;
            end
            TX_START: if (full_tick) state_d = TX_DATA;
            TX_DATA: if (full_tick) begin
                shreg_d = {1'b0, shreg[DATA_BITS-1:1]};
                if (idx == 4'(DATA_BITS - 1))
                    state_d = TX_STOP;
                else
                    idx_d = idx + 4'd1;
            end
            TX_STOP: if (full_tick) state_d = TX_IDLE;
            default: state_d = TX_IDLE;
        endcase
        tx_d = 1'b1;
        if (state_d == TX_START)
            tx_d = 1'b0;
        else if (state_d == TX_DATA)
            tx_d = shreg_d[0];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= TX_IDLE;
            shreg <= '0;
            idx   <= '0;
            tx    <= 1'b1;
        end else begin
            state <= state_d;
            shreg <= shreg_d;
            idx   <= idx_d;
            tx    <= tx_d;
        end
    end

endmodule

// File: rtl/uart_9n1.sv
// uart_9n1: 9N1 serial link top, independent transmitter and receiver.
// Parallel side through uart_9n1_if, serial lines as plain ports.
module uart_9n1
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clock,
    input  logic       reset_n,
    uart_9n1_if.slave  bus,
    output logic       tx,
    input  logic       rx
);

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clock   (clock),
        .reset_n (reset_n),
        .send    (bus.send),
        .data    (bus.tx_data),
        .tx      (tx),
        .ready   (bus.ready)
    );

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clock         (clock),
        .reset_n       (reset_n),
        .rx            (rx),
        .data          (bus.rx_data),
        .done          (bus.done),
        .framing_error (bus.framing_error)
    );

endmodule

// File: tb/tb_uart_9n1.sv
// tb_uart_9n1: directed bench for the 9N1 link, loopback and direct rx drive.
// Pulse counters sampled on the falling edge; all checks via check().
module tb_uart_9n1;

    localparam int N = 16;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic tx, rx;
    logic lb     = 1'b1;
    logic rx_drv = 1'b1;

    always #5 clock = ~clock;

    uart_9n1_if bus();

    assign rx = lb ? tx : rx_drv;

    uart_9n1 #(.CLKS_PER_BIT(N)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus),
        .tx      (tx),
        .rx      (rx)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    int   cyc = 0, n_done = 0, n_fe = 0, n_both = 0, n_rlow = 0;
    int   fall_prev = 0, fall_last = 0;
    logic rdy_q = 1'b1;

    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (bus.done) n_done <= n_done + 1;
        if (bus.framing_error) n_fe <= n_fe + 1;
        if (bus.done && bus.framing_error) n_both <= n_both + 1;
        if (!bus.ready) n_rlow <= n_rlow + 1;
        if (rdy_q && !bus.ready) begin
            fall_prev <= fall_last;
            fall_last <= cyc;
        end
        rdy_q <= bus.ready;
    end

    task automatic drive_frame(input logic [8:0] w, input logic stop);
        rx_drv = 1'b0;
        repeat (N) @(posedge clock);
        for (int i = 0; i < 9; i++) begin
            rx_drv = w[i];
            repeat (N) @(posedge clock);
        end
        rx_drv = stop;
        repeat (N) @(posedge clock);
    endtask

    task automatic pulse_send(input logic [8:0] w);
        bus.tx_data = w;
        bus.send    = 1'b1;
        @(posedge clock);
        #1 bus.send = 1'b0;
    endtask

    int bd, bf, br;
    logic [10:0] frm;

    initial begin
        bus.send    = 1'b0;
        bus.tx_data = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_tx", tx, 1);
        check("rst_ready", bus.ready, 1);
        check("rst_done", bus.done, 0);
        check("rst_fe", bus.framing_error, 0);
        check("rst_data", bus.rx_data, 0);
        reset_n = 1'b1;
        repeat (5) @(posedge clock);
        #1;

        // single frame in loopback, data changed mid-frame
        bd = n_done; bf = n_fe; br = n_rlow;
        frm = {1'b1, 9'h0D5, 1'b0};
        pulse_send(9'h0D5);
        bus.tx_data = 9'h1FF;
        check("ready_fall", bus.ready, 0);
        for (int k = 0; k < 11; k++) begin
            repeat (8) @(posedge clock);
            #1 check($sformatf("tx_bit%0d", k), tx, frm[k]);
            repeat (8) @(posedge clock);
            #1;
        end
        repeat (20) @(posedge clock);
        #1;
        check("ready_low", n_rlow - br, 176);
        check("one_done", n_done - bd, 1);
        check("one_fe", n_fe - bf, 0);
        check("one_data", bus.rx_data, 9'h0D5);

        // send held high for 5000 cycles
        bd = n_done; bf = n_fe;
        bus.tx_data = 9'h12A;
        bus.send    = 1'b1;
        repeat (5000) @(posedge clock);
        #1;
        check("cont_done", n_done - bd, 28);
        check("cont_fe", n_fe - bf, 0);
        check("cont_period", fall_last - fall_prev, 177);
        check("cont_both", n_both, 0);
        bus.send = 1'b0;
        repeat (400) @(posedge clock);
        #1;
        check("cont_data", bus.rx_data, 9'h12A);
        check("cont_idle", bus.ready, 1);

        // stop bit low, line then held low
        lb = 1'b0;
        rx_drv = 1'b1;
        repeat (40) @(posedge clock);
        #1;
        bd = n_done; bf = n_fe;
        drive_frame(9'h0AB, 1'b0);
        repeat (12 * N) @(posedge clock);
        #1;
        check("fe_count", n_fe - bf, 1);
        check("fe_done", n_done - bd, 0);
        check("fe_data", bus.rx_data, 9'h12A);
        rx_drv = 1'b1;
        repeat (40) @(posedge clock);
        #1;
        drive_frame(9'h0AB, 1'b1);
        repeat (40) @(posedge clock);
        #1;
        check("fe_rec_done", n_done - bd, 1);
        check("fe_rec_data", bus.rx_data, 9'h0AB);
        check("fe_rec_fe", n_fe - bf, 1);

        // 3-cycle glitch on idle line
        bd = n_done; bf = n_fe;
        rx_drv = 1'b0;
        repeat (3) @(posedge clock);
        #1 rx_drv = 1'b1;
        repeat (300) @(posedge clock);
        #1;
        check("gl_done", n_done - bd, 0);
        check("gl_fe", n_fe - bf, 0);
        drive_frame(9'h1C3, 1'b1);
        repeat (40) @(posedge clock);
        #1;
        check("gl_rec_done", n_done - bd, 1);
        check("gl_rec_data", bus.rx_data, 9'h1C3);

        // reset in the middle of a loopback frame
        lb = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        pulse_send(9'h155);
        repeat (80) @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_ready", bus.ready, 1);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_fe", bus.framing_error, 0);
        check("mid_rst_data", bus.rx_data, 0);
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        bd = n_done; bf = n_fe;
        pulse_send(9'h0F3);
        repeat (200) @(posedge clock);
        #1;
        check("post_rst_done", n_done - bd, 1);
        check("post_rst_fe", n_fe - bf, 0);
        check("post_rst_data", bus.rx_data, 9'h0F3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_9n1.md
# uart_9n1

Serial link block implementing 9N1 UART: 9 data bits, no parity, 1 stop bit, LSB first. It consists of two independent modules in one clock domain: `uart_tx` serializes a 9-bit word onto `tx`, and `uart_rx` deserializes `rx` and flags framing errors. It sits at the chip's serial I/O boundary; the bench loops `tx` back into `rx`.

## Interface
Parameters (both modules):
- CLKS_PER_BIT, default 16: clock cycles per bit period; must be an even number ≥ 4.

Ports, `uart_tx`:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- send  in  1  level request to transmit `data`
- data  in  9  word to transmit, sampled when a frame starts
- tx  out  1  serial line, idle high
- ready  out  1  high when idle and able to accept `send`

Ports, `uart_rx`:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- rx  in  1  serial line, asynchronous to `clock`
- data  out  9  last correctly received word
- done  out  1  one-cycle pulse when `data` is updated
- framing_error  out  1  one-cycle pulse when the stop bit is sampled low

## Operation
- Frame format: start bit (0), data[0] through data[8], stop bit (1). This gives 11 bit periods.
- `uart_tx` states are IDLE, START, DATA, STOP.
  - IDLE: `tx`=1, `ready`=1. On a rising edge with `send`=1, latch `data` and go to START.
  - START: drive 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: drive the latched bit i, i = 0..8, for CLKS_PER_BIT cycles each, then go to STOP.
  - STOP: drive 1 for CLKS_PER_BIT cycles, then return to IDLE.
  - `send` is level-sensitive. If it is still high in IDLE, the next frame starts on that edge. Holding `send` high therefore transmits the same word continuously.
  - Changes to `data` during a frame have no effect.
- `uart_rx` passes `rx` through a 2-flop synchronizer whose flops reset to 1. Its states are IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when the synchronized `rx` is 0, go to START.
  - START: after CLKS_PER_BIT/2 cycles (mid-bit), sample the line. If it is 0, go to DATA. If it is 1, treat it as a glitch and return to IDLE with no output pulse.
  - DATA: sample every CLKS_PER_BIT cycles at mid-bit, shifting LSB first, 9 samples in total.
  - STOP: sample at mid-bit.
    - If 1: load `data`, pulse `done`, and go to IDLE.
    - If 0: pulse `framing_error`, leave `data` unchanged, and go to WAIT_HIGH.
  - WAIT_HIGH: wait for the synchronized `rx` to be 1, then go to IDLE.
- `done` and `framing_error` are never high in the same cycle.

## Timing
- Reset values:
  - `tx`=1, `ready`=1.
  - `data`=0, `done`=0, `framing_error`=0.
  - Both FSMs in IDLE, all counters 0.
- Reset mid-frame aborts immediately. `tx` returns to 1 asynchronously.
- TX: `tx` falls and `ready` falls in the cycle after the edge that samples `send`=1. Each bit lasts exactly CLKS_PER_BIT cycles.
- TX: `ready` is high for at least one cycle between frames. With `send` held high, the frame period is 11·CLKS_PER_BIT+1 cycles.
- RX: the stop bit is sampled 2 (synchronizer) + CLKS_PER_BIT/2 + 10·CLKS_PER_BIT cycles after the falling edge of `rx`. `done` or `framing_error` is asserted on the following cycle for exactly one cycle.
- RX: `data` holds its value until the next good frame.
- RX: in loopback, the receiver returns to IDLE during the sender's stop bit, so back-to-back frames are received without loss.

## Structure
- Package `uart_pkg` contains:
  - localparams DATA_BITS=9 and FRAME_BITS=11
  - the default CLKS_PER_BIT
  - typedefs `tx_state_t` and `rx_state_t`
- Both modules use the sub-module `uart_bit_timer`, a bit-period counter with a clear input and `half_tick`/`full_tick` outputs.

## Test plan
- Reset, then idle: `tx`=1, `ready`=1, `done`=0, `framing_error`=0, `data`=0.
- Loopback, `data`=9'b0_1101_0101, `send` pulsed for 1 cycle:
  - `tx` emits 0, then 1,0,1,0,1,0,1,1,0, then 1, each bit 16 cycles.
  - `ready` is low for 176 cycles.
  - `done` pulses once and the received `data`=9'b0_1101_0101.
- Loopback, `send` held high for 5000 cycles:
  - 28 complete frames at a 177-cycle period.
  - 28 `done` pulses, no `framing_error`.
- Drive `rx` with a stop bit of 0: one `framing_error` pulse, no `done`, `data` unchanged. No new start is recognized until `rx` returns high.
- Drive a 3-cycle low glitch on idle `rx`: no `done`, no `framing_error`, FSM back in IDLE.
- Assert reset mid-frame: outputs return to reset values immediately. After reset is released, the next full frame is received correctly.
